// File: rtl/nasti_dm_arbiter.sv
// Round-robin arbiter sharing one data mover controller between NUM_REQ requesters.
// Optional RUN watchdog is enabled by defining NASTI_DM_ARB_TIMEOUT_EN.
module nasti_dm_arbiter #(
    parameter int ADDR_WIDTH     = 64,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int IDW           = $clog2(NUM_REQ)
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_src_addr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dest_addr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_length,
    output logic [NUM_REQ-1:0]            cmp_valid,
    output logic [NUM_REQ-1:0]            cmp_err,
    output logic [ADDR_WIDTH-1:0]         dm_src_addr,
    output logic [ADDR_WIDTH-1:0]         dm_dest_addr,
    output logic [ADDR_WIDTH-1:0]         dm_length,
    output logic                          dm_start,
    input  logic                          dm_done,
    output logic                          busy,
    output logic [IDW-1:0]                grant_id
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RUN,
        COMPLETE
    } state_t;

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("nasti_dm_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    state_t                  state;
    state_t                  state_nxt;
    logic [IDW-1:0]          rr_ptr;
    logic [IDW-1:0]          win_id;
    logic [IDW-1:0]          owner_nxt;
    logic                    win_found;
    logic                    accept;
    logic                    cmp_set;
    logic [ADDR_WIDTH-1:0]   win_src;
    logic [ADDR_WIDTH-1:0]   win_dst;
    logic [ADDR_WIDTH-1:0]   win_len;

    // Scan starts at rr_ptr so the last owner goes to the back of the line.
    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_id    = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign accept    = (state == IDLE) && win_found;
    assign req_ready = accept ? (NUM_REQ'(1) << win_id) : '0;
    assign win_src   = req_src_addr[int'(win_id)*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_dst   = req_dest_addr[int'(win_id)*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_len   = req_length[int'(win_id)*ADDR_WIDTH +: ADDR_WIDTH];
    assign owner_nxt = accept ? win_id : grant_id;
    assign dm_start  = (state == ISSUE);
    assign busy      = (state != IDLE);

`ifdef NASTI_DM_ARB_TIMEOUT_EN
    logic        err_set;
    logic        timeout_hit;
    logic [31:0] wd_cnt;

    assign timeout_hit = (state == RUN) && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Held at zero outside RUN, so it always starts from zero on RUN entry.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wd_cnt  <= '0;
            cmp_err <= '0;
        end else begin
            wd_cnt  <= (state == RUN) ? wd_cnt + 32'd1 : '0;
            cmp_err <= err_set ? (NUM_REQ'(1) << owner_nxt) : '0;
        end
    end
`else
    assign cmp_err = '0;
`endif

    always_comb begin
        state_nxt = state;
        cmp_set   = 1'b0;
`ifdef NASTI_DM_ARB_TIMEOUT_EN
        err_set   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    if (win_len == '0) begin
                        state_nxt = COMPLETE;
                        cmp_set   = 1'b1;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: state_nxt = RUN;
            RUN: begin
                if (dm_done) begin
                    state_nxt = COMPLETE;
                    cmp_set   = 1'b1;
                end
`ifdef NASTI_DM_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_nxt = COMPLETE;
                    cmp_set   = 1'b1;
                    err_set   = 1'b1;
                end
`endif
            end
            COMPLETE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            dm_src_addr  <= '0;
            dm_dest_addr <= '0;
            dm_length    <= '0;
            cmp_valid    <= '0;
        end else begin
            state     <= state_nxt;
            cmp_valid <= cmp_set ? (NUM_REQ'(1) << owner_nxt) : '0;
            if (accept) begin
                grant_id     <= win_id;
                dm_src_addr  <= win_src;
                dm_dest_addr <= win_dst;
                dm_length    <= win_len;
            end
            if (state == COMPLETE) begin
                rr_ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + IDW'(1);
            end
        end
    end

endmodule

// File: tb/tb_nasti_dm_arbiter.sv
// Self-checking bench for nasti_dm_arbiter: vector table, directed latency/reset
// sequences and a randomized run against a timestamp-based transaction model.
module tb_nasti_dm_arbiter;

    localparam int AW = 64;
    localparam int N  = 4;
    localparam int TO = 16;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_src_addr = '0;
    logic [N*AW-1:0] req_dest_addr = '0;
    logic [N*AW-1:0] req_length = '0;
    logic [N-1:0]    cmp_valid;
    logic [N-1:0]    cmp_err;
    logic [AW-1:0]   dm_src_addr;
    logic [AW-1:0]   dm_dest_addr;
    logic [AW-1:0]   dm_length;
    logic            dm_start;
    logic            dm_done = 1'b0;
    logic            busy;
    logic [1:0]      grant_id;

    nasti_dm_arbiter #(.ADDR_WIDTH(AW), .NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src_addr(req_src_addr), .req_dest_addr(req_dest_addr), .req_length(req_length),
        .cmp_valid(cmp_valid), .cmp_err(cmp_err),
        .dm_src_addr(dm_src_addr), .dm_dest_addr(dm_dest_addr), .dm_length(dm_length),
        .dm_start(dm_start), .dm_done(dm_done), .busy(busy), .grant_id(grant_id)
    );

    always #5 aclk = ~aclk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [63:0] src, input logic [63:0] dst,
                           input logic [63:0] len);
        req_valid[i]              = 1'b1;
        req_src_addr[i*AW +: AW]  = src;
        req_dest_addr[i*AW +: AW] = dst;
        req_length[i*AW +: AW]    = len;
    endtask

    task automatic do_reset();
        aresetn   = 1'b0;
        req_valid = '0;
        dm_done   = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] one;
        one = 1;
        return one << i;
    endfunction

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] exp_ready;
        logic [1:0]   exp_grant;
    } vec_t;

    vec_t vecs[8];

    // Transaction model: arbitration by rule, outputs derived from cycle timestamps.
    bit            m_busy, m_zero, m_err;
    int            m_owner, m_rr, m_acc_t, m_cmp_at;
    logic [63:0]   m_src, m_dst, m_len;
    bit            mv[N];
    logic [63:0]   ms[N], md[N], ml[N];

    initial begin
        // Zero-length requests; each row starts from the rr pointer left by the previous row.
        vecs[0] = '{4'b0001, 4'b0001, 2'd0};
        vecs[1] = '{4'b0001, 4'b0001, 2'd0};
        vecs[2] = '{4'b1111, 4'b0010, 2'd1};
        vecs[3] = '{4'b1001, 4'b1000, 2'd3};
        vecs[4] = '{4'b1110, 4'b0010, 2'd1};
        vecs[5] = '{4'b0011, 4'b0001, 2'd0};
        vecs[6] = '{4'b0100, 4'b0100, 2'd2};
        vecs[7] = '{4'b1101, 4'b1000, 2'd3};

        // Reset state
        aresetn = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_start", dm_start, 0);
        check("rst_cmp", cmp_valid, 0);
        check("rst_err", cmp_err, 0);
        check("rst_grant", grant_id, 0);
        check("rst_src", dm_src_addr, 0);
        check("rst_len", dm_length, 0);
        do_reset();

        for (int v = 0; v < 8; v++) begin
            req_valid = vecs[v].valid;
            settle();
            check($sformatf("vec%0d_ready", v), req_ready, vecs[v].exp_ready);
            check($sformatf("vec%0d_idle", v), busy, 0);
            tick();
            req_valid = '0;
            settle();
            check($sformatf("vec%0d_cmp", v), cmp_valid, vecs[v].exp_ready);
            check($sformatf("vec%0d_grant", v), grant_id, vecs[v].exp_grant);
            check($sformatf("vec%0d_nostart", v), dm_start, 0);
            tick();
        end

        // Single transfer latency
        do_reset();
        set_req(0, 64'h1000, 64'h2000, 64'h40);
        settle();
        check("t1_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        settle();
        check("t1_start", dm_start, 1);
        check("t1_src", dm_src_addr, 64'h1000);
        check("t1_dst", dm_dest_addr, 64'h2000);
        check("t1_len", dm_length, 64'h40);
        check("t1_ready_busy", req_ready, 0);
        tick();
        check("t1_start_once", dm_start, 0);
        tick();
        tick();
        check("t1_no_cmp_early", cmp_valid, 0);
        tick();
        dm_done = 1'b1;
        tick();
        dm_done = 1'b0;
        settle();
        check("t1_cmp", cmp_valid, 4'b0001);
        check("t1_cmp_err", cmp_err, 0);
        tick();
        check("t1_cmp_once", cmp_valid, 0);
        check("t1_idle", busy, 0);

        // Stray dm_done in IDLE and in the ISSUE cycle
        dm_done = 1'b1;
        tick();
        check("t4_idle_done_busy", busy, 0);
        check("t4_idle_done_cmp", cmp_valid, 0);
        dm_done = 1'b0;
        set_req(1, 64'hA0, 64'hB0, 64'h8);
        tick();
        req_valid = '0;
        dm_done   = 1'b1;
        settle();
        check("t4_issue", dm_start, 1);
        tick();
        dm_done = 1'b0;
        tick();
        check("t4_ignored_cmp", cmp_valid, 0);
        check("t4_ignored_busy", busy, 1);
        dm_done = 1'b1;
        tick();
        dm_done = 1'b0;
        settle();
        check("t4_cmp", cmp_valid, 4'b0010);

        // Reset in RUN abandons the transfer
        tick();
        set_req(0, 64'h11, 64'h22, 64'h4);
        tick();
        req_valid = '0;
        tick();
        tick();
        check("t5_run_busy", busy, 1);
        aresetn = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_start", dm_start, 0);
        check("t5_src", dm_src_addr, 0);
        check("t5_grant", grant_id, 0);
        dm_done = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        check("t5_no_cmp", cmp_valid, 0);
        dm_done = 1'b0;
        aresetn = 1'b1;
        set_req(1, 64'h33, 64'h44, 64'h10);
        settle();
        check("t5_ready1", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        settle();
        check("t5_start1", dm_start, 1);
        check("t5_grant1", grant_id, 1);
        tick();
        dm_done = 1'b1;
        tick();
        dm_done = 1'b0;
        settle();
        check("t5_cmp1", cmp_valid, 4'b0010);

`ifdef NASTI_DM_ARB_TIMEOUT_EN
        // Watchdog: no dm_done, completion 16 cycles after RUN entry
        do_reset();
        set_req(3, 64'h5, 64'h6, 64'h7);
        tick();
        req_valid = '0;
        repeat (16) tick();
        check("t6_no_cmp_early", cmp_valid, 0);
        tick();
        check("t6_cmp", cmp_valid, 4'b1000);
        check("t6_err", cmp_err, 4'b1000);
        tick();
        check("t6_idle", busy, 0);
        check("t6_err_once", cmp_err, 0);
`endif

        // Randomized run against the transaction model
        do_reset();
        m_busy = 0; m_zero = 0; m_err = 0;
        m_owner = 0; m_rr = 0; m_acc_t = -100; m_cmp_at = -1;
        m_src = 0; m_dst = 0; m_len = 0;
        for (int i = 0; i < N; i++) mv[i] = 0;
        for (int c = 0; c < 2000; c++) begin
            logic [N-1:0] e_ready;
            logic [N-1:0] e_cmp;
            logic [N-1:0] e_err;
            int           win;
            for (int i = 0; i < N; i++) begin
                if (!mv[i] && ($urandom % 4 == 0)) begin
                    mv[i] = 1;
                    ms[i] = {$urandom, $urandom};
                    md[i] = {$urandom, $urandom};
                    ml[i] = ($urandom % 4 == 0) ? 64'd0 : 64'(1 + $urandom % 4096);
                end
                req_valid[i]              = mv[i];
                req_src_addr[i*AW +: AW]  = ms[i];
                req_dest_addr[i*AW +: AW] = md[i];
                req_length[i*AW +: AW]    = ml[i];
            end
            dm_done = ($urandom % 3 == 0);
            settle();

            win = -1;
            if (!m_busy) begin
                for (int k = 0; k < N; k++)
                    if (win < 0 && mv[(m_rr + k) % N]) win = (m_rr + k) % N;
            end
            e_ready = (win >= 0) ? onehot(win) : '0;
            e_cmp   = (m_busy && c == m_cmp_at) ? onehot(m_owner) : '0;
            e_err   = (m_busy && c == m_cmp_at && m_err) ? onehot(m_owner) : '0;
            check("rnd_ready", req_ready, e_ready);
            check("rnd_start", dm_start, m_busy && !m_zero && c == m_acc_t + 1);
            check("rnd_cmp", cmp_valid, e_cmp);
            check("rnd_err", cmp_err, e_err);
            check("rnd_busy", busy, m_busy);
            check("rnd_grant", grant_id, m_owner);
            check("rnd_src", dm_src_addr, m_src);
            check("rnd_dst", dm_dest_addr, m_dst);
            check("rnd_len", dm_length, m_len);

            if (win >= 0) begin
                m_busy  = 1;
                m_owner = win;
                m_src   = ms[win];
                m_dst   = md[win];
                m_len   = ml[win];
                m_acc_t = c;
                m_zero  = (ml[win] == 0);
                m_err   = 0;
                m_cmp_at = m_zero ? c + 1 : -1;
                mv[win] = 0;
            end else if (m_busy) begin
                if (m_cmp_at < 0 && c >= m_acc_t + 2 && dm_done) begin
                    m_cmp_at = c + 1;
                end
`ifdef NASTI_DM_ARB_TIMEOUT_EN
                else if (m_cmp_at < 0 && c == m_acc_t + 2 + TO - 1) begin
                    m_cmp_at = c + 1;
                    m_err    = 1;
                end
`endif
                if (c == m_cmp_at) begin
                    m_busy = 0;
                    m_rr   = (m_owner + 1) % N;
                end
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
